// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types and constants for the CPU inst/data memory-port arbiter.
// Owner encoding is stored in the in-order owner FIFO.
package cpu_mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SIZE_W = 2;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic              wr;
        logic [SIZE_W-1:0] size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/cpu_mem_arbiter_owner_fifo.sv
// In-order FIFO of 1-bit owner tags for accepted, not yet answered transactions.
// Push is ignored when full and pop when empty, so callers may drive them raw.
module arb_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one sram-like port between CPU inst and data requesters: data priority,
// inst anti-starvation override, address-phase lock, in-order response routing.
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int MAX_OUT      = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [SIZE_W-1:0] inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [SIZE_W-1:0] data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [SIZE_W-1:0] mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_spurious
);

    arb_state_t state, state_nxt;
    logic       lock_owner, lock_owner_nxt;
    logic       owner;
    logic       granted_req;
    logic       accept;
    logic       inst_accept;
    logic [7:0] starve_cnt;
    logic       starve_flag;
    logic       fifo_full, fifo_empty, fifo_head;
    logic       rsp_valid;
    sram_req_t  inst_pl, data_pl, sel_pl;

    assign starve_flag = (starve_cnt == 8'(STARVE_LIMIT));

    // Grant and lock FSM; a locked owner keeps the bus until accepted.
    always_comb begin
        state_nxt      = state;
        lock_owner_nxt = lock_owner;
        owner          = OWNER_INST;
        if (state == ST_LOCKED)
            owner = lock_owner;
        else if (starve_flag && inst_req)
            owner = OWNER_INST;
        else if (data_req)
            owner = OWNER_DATA;

        granted_req = (owner == OWNER_DATA) ? data_req : inst_req;
        mem_req     = granted_req & ~fifo_full & ~reset;
        accept      = mem_req & mem_addr_ok;

        if (accept) begin
            state_nxt = ST_UNLOCKED;
        end else if (mem_req) begin
            state_nxt      = ST_LOCKED;
            lock_owner_nxt = owner;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_UNLOCKED;
            lock_owner <= OWNER_INST;
        end else begin
            state      <= state_nxt;
            lock_owner <= lock_owner_nxt;
        end
    end

    assign inst_pl = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
    assign data_pl = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
    assign sel_pl  = (owner == OWNER_DATA) ? data_pl : inst_pl;

    assign mem_wr    = sel_pl.wr;
    assign mem_size  = sel_pl.size;
    assign mem_addr  = sel_pl.addr;
    assign mem_wdata = sel_pl.wdata;

    assign inst_accept  = accept & (owner == OWNER_INST);
    assign inst_addr_ok = inst_accept;
    assign data_addr_ok = accept & (owner == OWNER_DATA);

    always_ff @(posedge clk) begin
        if (reset)
            starve_cnt <= '0;
        else if (!inst_req || inst_accept)
            starve_cnt <= '0;
        else if (!starve_flag)
            starve_cnt <= starve_cnt + 1'b1;
    end

    arb_owner_fifo #(.DEPTH(MAX_OUT)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .din   (owner),
        .pop   (mem_data_ok),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign rsp_valid    = mem_data_ok & ~fifo_empty & ~reset;
    assign inst_data_ok = rsp_valid & (fifo_head == OWNER_INST);
    assign data_data_ok = rsp_valid & (fifo_head == OWNER_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // Sticky once a response shows up with nothing outstanding.
    always_ff @(posedge clk) begin
        if (reset)
            err_spurious <= 1'b0;
        else if (mem_data_ok && fifo_empty)
            err_spurious <= 1'b1;
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench: stimulus pushes expected acceptances/responses into queues,
// a negedge monitor pops and compares whenever the DUT handshakes.
module tb_cpu_mem_arbiter;
    import cpu_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        err_spurious;

    int tests = 0;
    int fails = 0;

    typedef struct { logic owner; logic [31:0] addr; } acc_t;
    typedef struct { logic owner; logic [31:0] rdata; } rsp_t;
    acc_t exp_acc[$];
    rsp_t exp_rsp[$];

    always #5 clk = ~clk;

    cpu_mem_arbiter #(.MAX_OUT(2), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .err_spurious(err_spurious)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_txn(input logic owner, input logic [31:0] addr, input logic [31:0] rdata);
        acc_t a;
        rsp_t r;
        a.owner = owner; a.addr = addr;
        r.owner = owner; r.rdata = rdata;
        exp_acc.push_back(a);
        exp_rsp.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Monitor: acceptance order/routing and response order/routing.
    always @(negedge clk) begin
        acc_t a;
        rsp_t r;
        if (!reset) begin
            if (mem_req && mem_addr_ok) begin
                tests++;
                if (exp_acc.size() == 0) begin
                    fails++;
                    $display("FAIL accept_unexpected: addr=%h", mem_addr);
                end else begin
                    a = exp_acc.pop_front();
                    if ({inst_addr_ok, data_addr_ok} !== ((a.owner == OWNER_DATA) ? 2'b01 : 2'b10)
                        || mem_addr !== a.addr) begin
                        fails++;
                        $display("FAIL accept: inst_ok=%0b data_ok=%0b addr=%h expected owner=%0b addr=%h",
                                 inst_addr_ok, data_addr_ok, mem_addr, a.owner, a.addr);
                    end
                end
            end else if (inst_addr_ok || data_addr_ok) begin
                tests++;
                fails++;
                $display("FAIL addr_ok_stray: inst_ok=%0b data_ok=%0b expected 0 0", inst_addr_ok, data_addr_ok);
            end
            if (inst_data_ok || data_data_ok) begin
                tests++;
                if (exp_rsp.size() == 0) begin
                    fails++;
                    $display("FAIL rsp_unexpected: inst_ok=%0b data_ok=%0b", inst_data_ok, data_data_ok);
                end else begin
                    r = exp_rsp.pop_front();
                    if ({inst_data_ok, data_data_ok} !== ((r.owner == OWNER_DATA) ? 2'b01 : 2'b10)
                        || ((r.owner == OWNER_DATA) ? data_rdata : inst_rdata) !== r.rdata) begin
                        fails++;
                        $display("FAIL rsp: inst_ok=%0b data_ok=%0b rdata=%h expected owner=%0b rdata=%h",
                                 inst_data_ok, data_data_ok, mem_rdata, r.owner, r.rdata);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = SIZE_WORD; inst_addr = '0; inst_wdata = '0;
        data_req = 0; data_wr = 0; data_size = SIZE_WORD; data_addr = '0; data_wdata = '0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
        tick();
        // Requests during reset must not leak out.
        inst_req = 1; mem_addr_ok = 1;
        settle();
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("reset_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        tick();
        check("reset_err", {31'd0, err_spurious}, 32'd0);
        inst_req = 0;
        reset = 0;
        tick();

        // Single inst fetch, response 2 cycles later.
        inst_req = 1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1;
        expect_txn(OWNER_INST, 32'hBFC0_0000, 32'h3C08_BFAF);
        settle();
        check("fetch_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        tick();
        inst_req = 0;
        tick();
        mem_data_ok = 1; mem_rdata = 32'h3C08_BFAF;
        settle();
        check("fetch_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
        tick();
        mem_data_ok = 0;
        tick();

        // Both request together: data first, then inst; responses D then I.
        inst_req = 1; inst_addr = 32'h0000_2000;
        data_req = 1; data_addr = 32'h0000_1000; data_wr = 1; data_wdata = 32'hCAFE_0001;
        expect_txn(OWNER_DATA, 32'h0000_1000, 32'hD000_0001);
        expect_txn(OWNER_INST, 32'h0000_2000, 32'h1000_0001);
        settle();
        check("both_data_first", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
        check("both_mem_wdata", mem_wdata, 32'hCAFE_0001);
        tick();
        data_req = 0;
        tick();
        inst_req = 0;
        mem_data_ok = 1; mem_rdata = 32'hD000_0001;
        tick();
        mem_rdata = 32'h1000_0001;
        tick();
        mem_data_ok = 0;
        tick();
        check("both_count_zero", 32'(dut.u_fifo.count), 32'd0);

        // Lock: data stalled by mem_addr_ok=0, inst arrives, grant stays on data.
        mem_addr_ok = 0;
        data_req = 1; data_addr = 32'h0000_4000;
        for (int c = 0; c < 5; c++) begin
            if (c >= 2) begin inst_req = 1; inst_addr = 32'h0000_5000; end
            settle();
            check($sformatf("lock_addr_c%0d", c), mem_addr, 32'h0000_4000);
            check($sformatf("lock_inst_ok_c%0d", c), {31'd0, inst_addr_ok}, 32'd0);
            tick();
        end
        mem_addr_ok = 1;
        expect_txn(OWNER_DATA, 32'h0000_4000, 32'h4444_0000);
        expect_txn(OWNER_INST, 32'h0000_5000, 32'h5555_0000);
        settle();
        check("lock_release", {31'd0, data_addr_ok}, 32'd1);
        tick();
        data_req = 0;
        tick();
        inst_req = 0;
        mem_data_ok = 1; mem_rdata = 32'h4444_0000;
        tick();
        mem_rdata = 32'h5555_0000;
        tick();
        mem_data_ok = 0;
        tick();

        // Starvation: data streams every cycle, inst wins once its counter hits 8.
        data_wr = 0;
        for (int k = 0; k <= 10; k++) begin
            data_req = (k <= 9);
            inst_req = (k <= 8);
            data_addr = 32'h0000_3000 + 32'(4 * k);
            inst_addr = 32'h0000_9000;
            mem_addr_ok = 1;
            mem_data_ok = (k >= 1);
            mem_rdata = 32'hA000_0000 + 32'(k - 1);
            if (k == 8)
                expect_txn(OWNER_INST, 32'h0000_9000, 32'hA000_0000 + 32'(k));
            else if (k <= 9)
                expect_txn(OWNER_DATA, 32'h0000_3000 + 32'(4 * k), 32'hA000_0000 + 32'(k));
            settle();
            if (k == 7) check("starve_c7_inst_ok", {31'd0, inst_addr_ok}, 32'd0);
            if (k == 8) check("starve_cnt_at_8", 32'(dut.starve_cnt), 32'd8);
            if (k == 8) check("starve_c8_inst_ok", {31'd0, inst_addr_ok}, 32'd1);
            if (k == 9) check("starve_cnt_cleared", 32'(dut.starve_cnt), 32'd0);
            tick();
        end
        mem_data_ok = 0; data_req = 0; inst_req = 0;
        tick();

        // FIFO full: third request waits; a pop cycle still blocks the push.
        mem_addr_ok = 1;
        data_req = 1; data_addr = 32'h0000_6000;
        expect_txn(OWNER_DATA, 32'h0000_6000, 32'h0000_0011);
        tick();
        data_req = 0; inst_req = 1; inst_addr = 32'h0000_7000;
        expect_txn(OWNER_INST, 32'h0000_7000, 32'h0000_0022);
        tick();
        inst_req = 0; data_req = 1; data_addr = 32'h0000_8000;
        settle();
        check("full_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        mem_data_ok = 1; mem_rdata = 32'h0000_0011;
        settle();
        check("full_pop_blocks_push", {31'd0, mem_req}, 32'd0);
        tick();
        mem_data_ok = 0;
        expect_txn(OWNER_DATA, 32'h0000_8000, 32'h0000_0033);
        settle();
        check("full_push_after_pop", {31'd0, data_addr_ok}, 32'd1);
        tick();
        data_req = 0;
        mem_data_ok = 1; mem_rdata = 32'h0000_0022;
        tick();
        mem_rdata = 32'h0000_0033;
        tick();
        mem_data_ok = 0;
        tick();

        // Spurious response.
        mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
        settle();
        check("spur_no_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        check("spur_err_not_yet", {31'd0, err_spurious}, 32'd0);
        tick();
        mem_data_ok = 0;
        settle();
        check("spur_err_set", {31'd0, err_spurious}, 32'd1);
        tick();
        settle();
        check("spur_err_sticky", {31'd0, err_spurious}, 32'd1);
        reset = 1;
        tick();
        reset = 0;
        settle();
        check("spur_err_cleared", {31'd0, err_spurious}, 32'd0);
        tick();

        check("acc_queue_empty", 32'(exp_acc.size()), 32'd0);
        check("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one sram-like memory port between the CPU instruction-fetch and data-access requesters, ahead of a single memory/AXI bridge.
- Arbitrates address phases, using data-priority with an inst anti-starvation override.
- Tracks outstanding transactions in an in-order owner FIFO and routes each data_ok/rdata back to the requester that issued it.

Parameters:
- MAX_OUT, 2: maximum outstanding accepted-but-unanswered transactions; power of two, >=1.
- STARVE_LIMIT, 8: consecutive cycles inst may be denied while requesting before it gets priority; 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  inst address-phase request
- inst_wr  in  1  write flag (0 for fetch)
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  32  byte address
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  inst address phase accepted
- inst_data_ok  out  1  inst response valid
- inst_rdata  out  32  inst read data
- data_req, data_wr, data_size, data_addr, data_wdata  in  1/1/2/32/32  data requester, same meaning as inst_*
- data_addr_ok, data_data_ok, data_rdata  out  1/1/32  data requester responses
- mem_req, mem_wr, mem_size, mem_addr, mem_wdata  out  1/1/2/32/32  downstream request
- mem_addr_ok  in  1  downstream accepted address phase
- mem_data_ok  in  1  downstream response, strictly in order
- mem_rdata  in  32  downstream read data
- err_spurious  out  1  sticky: mem_data_ok arrived with no outstanding transaction

Behaviour:
- Handshake: a requester holds req and payload stable until its addr_ok. A transaction is accepted in any cycle with mem_req & mem_addr_ok. Each accepted request gets exactly one data_ok in a later cycle; there is no same-cycle data_ok.
- Lock: when mem_req=1 and mem_addr_ok=0, lock_valid is set and lock_owner is registered. The grant stays with lock_owner until its addr_ok, regardless of priority or starvation. The lock clears on acceptance.
- Grant when unlocked:
  - If starve_flag is set and inst_req=1, inst wins.
  - Otherwise, if data_req=1, data wins.
  - Otherwise, if inst_req=1, inst wins.
- mem_req = granted_req & ~fifo_full. The mem_* payload is muxed from the granted owner.
- addr_ok routing: x_addr_ok = mem_addr_ok & mem_req & (owner==x). A non-granted requester always sees addr_ok=0.
- fifo_full: fifo_full = (count==MAX_OUT), computed from the registered count. A same-cycle pop does not allow a push while full, which avoids a combinational loop from mem_data_ok to mem_req.
- Owner FIFO: an acceptance pushes the 1-bit owner; mem_data_ok with count>0 pops the head.
  - Push and pop in the same cycle leave count unchanged and advance both pointers.
  - Pointers wrap modulo MAX_OUT.
- Response routing:
  - x_data_ok = mem_data_ok & (count>0) & (head==x).
  - inst_rdata and data_rdata both equal mem_rdata (broadcast), qualified only by data_ok.
- Spurious response: mem_data_ok with count==0 is ignored (no pop, no data_ok). err_spurious is set the next cycle and held until reset.
- Starvation counter (8-bit):
  - Increments each cycle inst_req=1 and inst is not accepted.
  - Clears on inst acceptance or when inst_req=0.
  - Saturates at STARVE_LIMIT.
  - starve_flag = (counter==STARVE_LIMIT).
- Reset (synchronous, 1 cycle):
  - count, pointers, lock_valid, starvation counter and err_spurious all go to 0.
  - Until the first post-reset cycle, all addr_ok/data_ok and mem_req outputs are 0.
  - Outstanding transactions are dropped; downstream is reset together with this block.
- Latency: zero-cycle combinational pass-through on both request and response paths. No bubbles are inserted.

Decomposition:
- Shared package/defines: OWNER_INST=1'b0, OWNER_DATA=1'b1; the size encodings SIZE_BYTE/HALF/WORD; the sram-like bus field widths.
- One sub-module, arb_owner_fifo (parameter DEPTH, 1-bit entries, push/pop/full/empty/head). The arbitration FSM (UNLOCKED/LOCKED) and the starvation counter stay in the top.

Test Plan:
- Reset, then inst_req only to 0xBFC00000 with mem_addr_ok=1 and mem_data_ok 2 cycles later, rdata=0x3C08BFAF -> inst_addr_ok=1 the same cycle; inst_data_ok=1 with inst_rdata=0x3C08BFAF; data_data_ok stays 0.
- inst_req and data_req both high from cycle 0, mem_addr_ok=1 each cycle, MAX_OUT=2, two mem_data_ok returned in order -> data accepted first, inst second; responses route D then I; count returns to 0.
- mem_addr_ok held 0 for 5 cycles while data is granted, then inst_req rises -> mem_addr stays the data address throughout (lock); inst_addr_ok=0 until data is accepted.
- data_req held high continuously with inst_req high and STARVE_LIMIT=8 -> inst is accepted on the cycle after its counter reaches 8; the counter then clears to 0.
- Three accepted requests with no responses, MAX_OUT=2 -> the third sees mem_req=0 until the first mem_data_ok. A pop cycle still blocks the push, so the push happens one cycle later.
- mem_data_ok pulse with no outstanding transaction -> no data_ok on either port; err_spurious=1 next cycle, and 0 after reset.
